// File: rtl/data_path_pkg.sv
// Shared encodings for the multicycle MIPS-subset datapath: opcodes, functs,
// control state codes, ALU operations and small decode helpers.
package data_path_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [31:0] RESET_PC  = 32'd0;
    localparam logic [31:0] RESET_NPC = 32'd4;

    typedef enum logic [6:0] {
        S_RESET      = 7'd0,
        S_FETCH_ADDR = 7'd1,
        S_FETCH_WAIT = 7'd2,
        S_DECODE     = 7'd3,
        S_ALU_R      = 7'd10,
        S_ALU_I      = 7'd11,
        S_LUI        = 7'd12,
        S_MEM_ADDR   = 7'd20,
        S_LOAD_WAIT  = 7'd21,
        S_STORE_WAIT = 7'd22,
        S_BEQ        = 7'd30,
        S_J          = 7'd31
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    // Unknown opcodes and functs fall through to the next fetch (NOP).
    function automatic state_e decode_class(input logic [5:0] op, input logic [5:0] fn);
        state_e s;
        s = S_FETCH_ADDR;
        case (op)
            OP_RTYPE: if (fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT}) s = S_ALU_R;
            OP_ADDIU, OP_ORI: s = S_ALU_I;
            OP_LUI: s = S_LUI;
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: s = S_MEM_ADDR;
            OP_BEQ: s = S_BEQ;
            OP_J: s = S_J;
            default: s = S_FETCH_ADDR;
        endcase
        return s;
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
        alu_op_e a;
        case (fn)
            FN_SUBU: a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/data_path_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; r0 always reads zero and ignores writes.
module data_path_regfile
    import data_path_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];

endmodule

// File: rtl/data_path.sv
// Multicycle MIPS-subset datapath with its control FSM, ALU and operand muxes;
// talks to a byte-addressed memory over a MOV/RW/MOC handshake.
module data_path
    import data_path_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MOC,
    input  logic        DMOC,
    input  logic [31:0] DataOut,
    output logic [31:0] IR,
    output logic [31:0] MAR,
    output logic [31:0] PC,
    output logic [31:0] nPC,
    output logic [31:0] DataIn,
    output logic [31:0] MUXA_o,
    output logic [31:0] MUXB_o,
    output logic [31:0] ALU_out,
    output logic        RW,
    output logic        MOV,
    output logic        RF,
    output logic [6:0]  aState,
    output logic [5:0]  OpC,
    output logic [4:0]  MA_o,
    output logic [4:0]  B_o
);

    state_e      state_q;
    logic [31:0] pc_q, npc_q, ir_q, mar_q;

    logic [5:0]  op, fn;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [31:0] imm_sx, imm_zx;
    logic [31:0] rs_val, rt_val;
    logic [31:0] muxa, muxb, alu_res;
    logic [31:0] load_data, wb_data;
    logic [31:0] npc_seq_d, jmp_tgt_d;
    alu_op_e     alu_op;
    logic        rf_we;
    logic        unused_shamt;

    assign op     = ir_q[31:26];
    assign fn     = ir_q[5:0];
    assign rs_a   = ir_q[25:21];
    assign rt_a   = ir_q[20:16];
    assign rd_a   = ir_q[15:11];
    assign imm_sx = sext16(ir_q[15:0]);
    assign imm_zx = {16'd0, ir_q[15:0]};
    assign unused_shamt = ^ir_q[10:6];

    assign npc_seq_d = npc_q + 32'd4;
    assign jmp_tgt_d = {pc_q[31:28], ir_q[25:0], 2'b00};

    // Operand selection; in BEQ the ALU forms the branch target from PC.
    always_comb begin
        muxa   = rs_val;
        muxb   = rt_val;
        alu_op = ALU_ADD;
        case (state_q)
            S_ALU_R: alu_op = funct_to_alu(fn);
            S_ALU_I: begin
                muxb   = (op == OP_ORI) ? imm_zx : imm_sx;
                alu_op = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_LUI: begin
                muxb   = imm_zx;
                alu_op = ALU_LUI;
            end
            S_MEM_ADDR: muxb = imm_sx;
            S_BEQ: begin
                muxa = pc_q;
                muxb = {imm_sx[29:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_ADD: alu_res = muxa + muxb;
            ALU_SUB: alu_res = muxa - muxb;
            ALU_AND: alu_res = muxa & muxb;
            ALU_OR:  alu_res = muxa | muxb;
            ALU_SLT: alu_res = {31'd0, $signed(muxa) < $signed(muxb)};
            ALU_LUI: alu_res = {muxb[15:0], 16'd0};
            default: alu_res = muxa + muxb;
        endcase
    end

    assign load_data = (op == OP_LB) ? {{24{DataOut[7]}}, DataOut[7:0]} : DataOut;
    assign wb_data   = (state_q == S_LOAD_WAIT) ? load_data : alu_res;

    assign rf_we = (state_q == S_ALU_R) || (state_q == S_ALU_I) || (state_q == S_LUI) ||
                   ((state_q == S_LOAD_WAIT) && DMOC);

    data_path_regfile u_rf (
        .clk       (clk),
        .reset     (reset),
        .we_i      (rf_we),
        .waddr_i   (MA_o),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_a),
        .raddr_b_i (rt_a),
        .rdata_a_o (rs_val),
        .rdata_b_o (rt_val)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_NPC;
            ir_q    <= '0;
            mar_q   <= '0;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_FETCH_ADDR;
                S_FETCH_ADDR: begin
                    mar_q   <= pc_q;
                    state_q <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: if (MOC) begin
                    ir_q    <= DataOut;
                    pc_q    <= npc_q;
                    npc_q   <= npc_seq_d;
                    state_q <= S_DECODE;
                end
                S_DECODE: state_q <= decode_class(op, fn);
                S_MEM_ADDR: begin
                    mar_q   <= alu_res;
                    state_q <= is_store_op(op) ? S_STORE_WAIT : S_LOAD_WAIT;
                end
                S_LOAD_WAIT, S_STORE_WAIT: if (DMOC) state_q <= S_FETCH_ADDR;
                // PC already points at the delay slot, so only nPC is redirected.
                S_BEQ: begin
                    if (rs_val == rt_val) npc_q <= alu_res;
                    state_q <= S_FETCH_ADDR;
                end
                S_J: begin
                    npc_q   <= jmp_tgt_d;
                    state_q <= S_FETCH_ADDR;
                end
                default: state_q <= S_FETCH_ADDR;
            endcase
        end
    end

    assign IR      = ir_q;
    assign MAR     = mar_q;
    assign PC      = pc_q;
    assign nPC     = npc_q;
    assign aState  = state_q;
    assign DataIn  = rt_val;
    assign MUXA_o  = muxa;
    assign MUXB_o  = muxb;
    assign ALU_out = alu_res;
    assign RF      = rf_we;
    assign MOV     = (state_q == S_FETCH_WAIT) || (state_q == S_LOAD_WAIT) ||
                     (state_q == S_STORE_WAIT);
    assign RW      = (state_q != S_STORE_WAIT);
    assign OpC     = (state_q == S_FETCH_WAIT) ? OP_LW : op;
    assign MA_o    = (state_q == S_ALU_R) ? rd_a : rt_a;
    assign B_o     = rt_a;

endmodule

// File: tb/tb_data_path.sv
// Directed program run on data_path against a 512-byte big-endian memory model,
// with hand-computed expectations for states, operands and stored data.
module tb_data_path;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold_f = 1'b1;
    logic        hold_d = 1'b0;
    logic        MOC, DMOC;
    logic [31:0] DataOut;
    logic [31:0] IR, MAR, PC, nPC, DataIn, MUXA_o, MUXB_o, ALU_out;
    logic        RW, MOV, RF;
    logic [6:0]  aState;
    logic [5:0]  OpC;
    logic [4:0]  MA_o, B_o;

    logic [7:0]  mem [512];
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    data_path dut (
        .clk(clk), .reset(reset), .MOC(MOC), .DMOC(DMOC), .DataOut(DataOut),
        .IR(IR), .MAR(MAR), .PC(PC), .nPC(nPC), .DataIn(DataIn),
        .MUXA_o(MUXA_o), .MUXB_o(MUXB_o), .ALU_out(ALU_out),
        .RW(RW), .MOV(MOV), .RF(RF), .aState(aState), .OpC(OpC),
        .MA_o(MA_o), .B_o(B_o)
    );

    // Zero-latency memory; hold_f / hold_d stretch the fetch / data handshakes.
    assign MOC  = MOV && !hold_f;
    assign DMOC = MOV && !hold_d;

    logic [8:0] ma;
    assign ma = MAR[8:0];
    always_comb begin
        if (OpC == 6'h20 || OpC == 6'h24 || OpC == 6'h28)
            DataOut = {24'd0, mem[ma]};
        else
            DataOut = {mem[ma], mem[ma + 9'd1], mem[ma + 9'd2], mem[ma + 9'd3]};
    end

    always @(posedge clk) begin
        if (reset && MOV && !RW && DMOC) begin
            if (OpC == 6'h28) begin
                mem[ma] <= DataIn[7:0];
            end else begin
                mem[ma]        <= DataIn[31:24];
                mem[ma + 9'd1] <= DataIn[23:16];
                mem[ma + 9'd2] <= DataIn[15:8];
                mem[ma + 9'd3] <= DataIn[7:0];
            end
        end
    end

    function automatic logic [31:0] memw(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    task automatic putw(input int a, input logic [31:0] w);
        mem[a] = w[31:24]; mem[a + 1] = w[23:16]; mem[a + 2] = w[15:8]; mem[a + 3] = w[7:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [6:0] s, input string tag);
        int n;
        n = 0;
        while (aState !== s && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_reach"}, {25'd0, aState}, {25'd0, s});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        putw(32'h000, 32'h24010005); // ADDIU r1,r0,5
        putw(32'h004, 32'hAC0101C0); // SW   r1,0x1C0(r0)
        putw(32'h008, 32'h10000002); // BEQ  r0,r0,+2
        putw(32'h00C, 32'h8C0201C0); // LW   r2,0x1C0(r0)  delay slot
        putw(32'h010, 32'h24030077); // ADDIU r3 (skipped)
        putw(32'h014, 32'h00222021); // ADDU r4,r1,r2
        putw(32'h018, 32'h00012823); // SUBU r5,r0,r1
        putw(32'h01C, 32'h00A1302A); // SLT  r6,r5,r1
        putw(32'h020, 32'h3C071234); // LUI  r7,0x1234
        putw(32'h024, 32'h34E78765); // ORI  r7,r7,0x8765
        putw(32'h028, 32'hA00501C4); // SB   r5,0x1C4
        putw(32'h02C, 32'h800801C4); // LB   r8,0x1C4
        putw(32'h030, 32'h900901C4); // LBU  r9,0x1C4
        putw(32'h034, 32'hAC0301C8); // SW   r3,0x1C8
        putw(32'h038, 32'h00E55024); // AND  r10,r7,r5
        putw(32'h03C, 32'h08000040); // J    0x100
        putw(32'h040, 32'hAC0A01CC); // SW   r10,0x1CC  delay slot
        putw(32'h044, 32'h240B0001); // ADDIU r11 (skipped)
        putw(32'h100, 32'hAC0401D0);
        putw(32'h104, 32'hAC0601D4);
        putw(32'h108, 32'hAC0701D8);
        putw(32'h10C, 32'hAC0801DC);
        putw(32'h110, 32'hAC0901E0);
        putw(32'h114, 32'hAC0501E4);
        putw(32'h118, 32'h24000007); // ADDIU r0,r0,7
        putw(32'h11C, 32'hAC0001E8); // SW   r0,0x1E8
        putw(32'h120, 32'h08000048); // J    0x120
        putw(32'h1C8, 32'hAAAAAAAA);
        putw(32'h1E8, 32'hAAAAAAAA);

        tick(); tick();
        chk("rst_state", {25'd0, aState}, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_npc", nPC, 32'd4);
        chk("rst_ir", IR, 32'd0);
        chk("rst_mar", MAR, 32'd0);
        chk("rst_ctl", {29'd0, MOV, RF, RW}, 32'b001);

        reset = 1'b1;
        tick();
        chk("st1", {25'd0, aState}, 32'd1);
        tick();
        chk("st2", {25'd0, aState}, 32'd2);
        chk("fetch_ctl", {29'd0, MOV, RW, 1'b0}, 32'b110);
        chk("fetch_opc", {26'd0, OpC}, 32'h23);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("moc_hold_state", {25'd0, aState}, 32'd2);
            chk("moc_hold_ir", IR, 32'd0);
        end
        hold_f = 1'b0;
        tick();
        chk("dec_state", {25'd0, aState}, 32'd3);
        chk("dec_ir", IR, 32'h24010005);
        chk("dec_pc", PC, 32'd4);
        chk("dec_npc", nPC, 32'd8);
        tick();
        chk("addiu_state", {25'd0, aState}, 32'd11);
        chk("addiu_alu", ALU_out, 32'd5);
        chk("addiu_rf", {31'd0, RF}, 32'd1);
        chk("addiu_ma", {27'd0, MA_o}, 32'd1);
        tick();
        chk("addiu_rf_pulse", {31'd0, RF}, 32'd0);

        wait_state(7'd22, "sw");
        chk("sw_rw", {31'd0, RW}, 32'd0);
        chk("sw_mar", MAR, 32'h1C0);
        chk("sw_data", DataIn, 32'd5);
        chk("sw_opc", {26'd0, OpC}, 32'h2B);
        tick();
        chk("sw_rw_after", {31'd0, RW}, 32'd1);
        chk("sw_mem", memw(32'h1C0), 32'h00000005);

        wait_state(7'd30, "beq");
        chk("beq_muxa", MUXA_o, 32'd12);
        chk("beq_muxb", MUXB_o, 32'd8);
        chk("beq_target", ALU_out, 32'd20);
        wait_state(7'd21, "lw");
        chk("lw_rw", {31'd0, RW}, 32'd1);
        chk("lw_mar", MAR, 32'h1C0);
        chk("lw_rf", {26'd0, RF, MA_o}, {26'd0, 1'b1, 5'd2});
        wait_state(7'd2, "post_branch_fetch");
        chk("branch_fetch_addr", MAR, 32'd20);

        wait_state(7'd10, "addu");
        chk("addu_alu", ALU_out, 32'd10);
        chk("addu_ma", {27'd0, MA_o}, 32'd4);
        tick();
        wait_state(7'd10, "subu");
        chk("subu_alu", ALU_out, 32'hFFFFFFFB);
        tick();
        wait_state(7'd10, "slt");
        chk("slt_alu", ALU_out, 32'd1);
        tick();
        wait_state(7'd12, "lui");
        chk("lui_alu", ALU_out, 32'h12340000);
        tick();
        wait_state(7'd11, "ori");
        chk("ori_muxb", MUXB_o, 32'h00008765);
        chk("ori_alu", ALU_out, 32'h12348765);
        tick();
        wait_state(7'd22, "sb");
        chk("sb_opc", {26'd0, OpC}, 32'h28);
        chk("sb_data", DataIn, 32'hFFFFFFFB);
        tick();
        hold_d = 1'b1;
        wait_state(7'd21, "lb");
        chk("lb_stall_rf", {31'd0, RF}, 32'd0);
        tick(); tick();
        chk("lb_stall_state", {25'd0, aState}, 32'd21);
        chk("lb_stall_rf2", {31'd0, RF}, 32'd0);
        hold_d = 1'b0;
        #1;
        chk("lb_done_rf", {31'd0, RF}, 32'd1);

        n = 0;
        while (!(aState === 7'd2 && MAR === 32'h120) && n < 400) begin
            tick();
            n++;
        end
        chk("final_loop_mar", MAR, 32'h120);
        chk("mem_sb", {24'd0, mem[9'h1C4]}, 32'hFB);
        chk("mem_skip_r3", memw(32'h1C8), 32'h00000000);
        chk("mem_and_delay", memw(32'h1CC), 32'h12348761);
        chk("mem_addu", memw(32'h1D0), 32'h0000000A);
        chk("mem_slt", memw(32'h1D4), 32'h00000001);
        chk("mem_lui_ori", memw(32'h1D8), 32'h12348765);
        chk("mem_lb", memw(32'h1DC), 32'hFFFFFFFB);
        chk("mem_lbu", memw(32'h1E0), 32'h000000FB);
        chk("mem_subu", memw(32'h1E4), 32'hFFFFFFFB);
        chk("mem_r0", memw(32'h1E8), 32'h00000000);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_state(7'd21, "rerun_lw");
        reset = 1'b0;
        tick();
        chk("midload_state", {25'd0, aState}, 32'd0);
        chk("midload_pc", PC, 32'd0);
        chk("midload_npc", nPC, 32'd4);
        chk("midload_ir", IR, 32'd0);
        chk("midload_ctl", {29'd0, MOV, RF, RW}, 32'b001);
        reset = 1'b1;
        tick();
        chk("midload_restart", {25'd0, aState}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
